// File: rtl/pulse_period_meter_pkg.sv
// Shared types and defaults for the pulse period meter.
// Latency: n/a (declarations only).
// Backpressure: n/a. Optional timeout feature macro: PERIOD_METER_TIMEOUT_EN.
package pulse_period_meter_pkg;

  localparam int DEF_W           = 16;
  localparam int DEF_TIMEOUT_CYC = 1000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    MEASURE = 2'd2
  } state_t;

endpackage

// File: rtl/pulse_period_meter_if.sv
// Result channel of the period meter: value, qualifier flags, valid/ready.
// Latency: n/a (wiring only).
// Backpressure: consumer holds period_ready low; producer keeps the result stable.
// period_tmo exists only when PERIOD_METER_TIMEOUT_EN is defined.
interface pulse_period_meter_if import pulse_period_meter_pkg::*; #(
  parameter int W = DEF_W
) ();

  logic [W-1:0] period_out;
  logic         period_ovf;
  logic         period_valid;
  logic         period_ready;
`ifdef PERIOD_METER_TIMEOUT_EN
  logic         period_tmo;

  modport master (
    output period_out, period_ovf, period_tmo, period_valid,
    input  period_ready
  );

  modport slave (
    input  period_out, period_ovf, period_tmo, period_valid,
    output period_ready
  );
`else
  modport master (
    output period_out, period_ovf, period_valid,
    input  period_ready
  );

  modport slave (
    input  period_out, period_ovf, period_valid,
    output period_ready
  );
`endif

endinterface

// File: rtl/pulse_period_meter_edge.sv
// Rising-edge detector against a registered copy of the input.
// Latency: rise is combinational from d; the history register costs one cycle.
// Backpressure: none; the history register updates every cycle.
module rise_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic sig_d;

  // Keep last cycle's input so a 0->1 step can be recognised.
  always_ff @(posedge clk) begin
    if (reset) sig_d <= 1'b0;
    else       sig_d <= d;
  end

  assign rise = d & ~sig_d;

endmodule

// File: rtl/pulse_period_meter.sv
// Measures clk cycles between consecutive sig_in rising edges; one result per edge.
// Latency: result valid the cycle after the closing edge; no dead time between periods.
// Backpressure: one-deep result register; a capture while it is unaccepted is dropped and sets sticky overrun.
// Optional timeout result enabled by macro PERIOD_METER_TIMEOUT_EN.
module pulse_period_meter import pulse_period_meter_pkg::*; #(
  parameter int W           = DEF_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  sig_in,
  output logic                  overrun,
  pulse_period_meter_if.master  res
);

  localparam logic [W-1:0] CNT_MAX = '1;
  localparam logic [W-1:0] CNT_ONE = W'(1);

  // Reject a timeout limit the counter could never reach (or that is degenerate).
  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > (2**W) - 1) begin : g_bad_timeout
    $error("pulse_period_meter: TIMEOUT_CYC out of range for W");
  end

`ifdef PERIOD_METER_TIMEOUT_EN
  localparam logic [W-1:0] TMO_VAL = W'(TIMEOUT_CYC);
  logic cap_tmo;
`endif

  state_t       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic         ovf_q, ovf_d;
  logic         rise;
  logic         cap;
  logic [W-1:0] cap_val;
  logic         cap_ovf;

  rise_edge_detect u_edge (
    .clk   (clk),
    .reset (reset),
    .d     (sig_in),
    .rise  (rise)
  );

  // State, period counter and saturation bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next state, counter update and capture request.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    cap     = 1'b0;
    cap_val = cnt_q;
    cap_ovf = ovf_q;
`ifdef PERIOD_METER_TIMEOUT_EN
    cap_tmo = 1'b0;
`endif
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: state_d = ARMED;
        ARMED: begin
          // First edge only opens the first period.
          if (rise) begin
            state_d = MEASURE;
            cnt_d   = CNT_ONE;
            ovf_d   = 1'b0;
          end
        end
        MEASURE: begin
          if (rise) begin
            // Close this period and open the next on the same edge.
            cap   = 1'b1;
            cnt_d = CNT_ONE;
            ovf_d = 1'b0;
          end
`ifdef PERIOD_METER_TIMEOUT_EN
          else if (cnt_q == TMO_VAL) begin
            cap     = 1'b1;
            cap_val = TMO_VAL;
            cap_ovf = 1'b0;
            cap_tmo = 1'b1;
            state_d = ARMED;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end
`endif
          else if (cnt_q == CNT_MAX) begin
            // Counter holds at max; flag that the true period was longer.
            ovf_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // One-deep result register with valid/ready handshake and sticky overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      res.period_out   <= '0;
      res.period_ovf   <= 1'b0;
      res.period_valid <= 1'b0;
`ifdef PERIOD_METER_TIMEOUT_EN
      res.period_tmo   <= 1'b0;
`endif
      overrun          <= 1'b0;
    end else if (cap) begin
      if (res.period_valid && !res.period_ready) begin
        overrun <= 1'b1;
      end else begin
        res.period_out   <= cap_val;
        res.period_ovf   <= cap_ovf;
`ifdef PERIOD_METER_TIMEOUT_EN
        res.period_tmo   <= cap_tmo;
`endif
        res.period_valid <= 1'b1;
      end
    end else if (res.period_valid && res.period_ready) begin
      res.period_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pulse_period_meter.sv
// Directed bench for pulse_period_meter: a W=16 instance plus a W=4 instance for saturation.
// Both share clk, reset, en, sig_in and ready; accepted results of the W=16 instance are logged.
// Timeout scenario is exercised when PERIOD_METER_TIMEOUT_EN is defined.
module tb_pulse_period_meter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b0;
  logic sig_in = 1'b0;
  logic ready = 1'b0;
  logic overrun, overrun4;

  int n_chk = 0;
  int n_bad = 0;

  logic [15:0] acc_val[$];
  logic        acc_ovf[$];
  logic        acc_tmo[$];

  pulse_period_meter_if #(.W(16)) bus ();
  pulse_period_meter_if #(.W(4))  bus4 ();

  assign bus.period_ready  = ready;
  assign bus4.period_ready = ready;

  pulse_period_meter #(.W(16), .TIMEOUT_CYC(50)) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .sig_in  (sig_in),
    .overrun (overrun),
    .res     (bus)
  );

  pulse_period_meter #(.W(4), .TIMEOUT_CYC(15)) dut4 (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .sig_in  (sig_in),
    .overrun (overrun4),
    .res     (bus4)
  );

  always #5 clk = ~clk;

  // Log every handshake of the W=16 instance (inputs settle well before negedge).
  always @(negedge clk) begin
    if (!reset && bus.period_valid && bus.period_ready) begin
      acc_val.push_back(bus.period_out);
      acc_ovf.push_back(bus.period_ovf);
`ifdef PERIOD_METER_TIMEOUT_EN
      acc_tmo.push_back(bus.period_tmo);
`else
      acc_tmo.push_back(1'b0);
`endif
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    en     = 1'b0;
    sig_in = 1'b0;
    ready  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    acc_val.delete();
    acc_ovf.delete();
    acc_tmo.delete();
  endtask

  task automatic arm();
    en = 1'b1;
    tick();
    tick();
  endtask

  task automatic pulse();
    sig_in = 1'b1;
    tick();
    sig_in = 1'b0;
  endtask

  // With pulse() before and after, gives edges exactly k cycles apart.
  task automatic gap(input int k);
    repeat (k - 1) tick();
  endtask

  task automatic pulse_rdy();
    sig_in = 1'b1;
    ready  = 1'b1;
    tick();
    sig_in = 1'b0;
    ready  = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_valid", 32'(bus.period_valid), 32'd0);
    chk("rst_out", 32'(bus.period_out), 32'd0);
    chk("rst_ovf", 32'(bus.period_ovf), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);

    // Edges at 10, 15, 22 with ready held high -> 5 then 7
    ready = 1'b1;
    arm();
    pulse(); gap(5); pulse(); gap(7); pulse();
    repeat (3) tick();
    chk("basic_cnt", 32'(acc_val.size()), 32'd2);
    if (acc_val.size() == 2) begin
      chk("basic_r0", 32'(acc_val[0]), 32'd5);
      chk("basic_r1", 32'(acc_val[1]), 32'd7);
      chk("basic_ovf", 32'({acc_ovf[0], acc_ovf[1]}), 32'd0);
    end
    chk("basic_overrun", 32'(overrun), 32'd0);

    // Toggling every cycle -> period 2
    do_reset();
    ready = 1'b1;
    arm();
    repeat (4) begin
      sig_in = 1'b1; tick();
      sig_in = 1'b0; tick();
    end
    repeat (2) tick();
    chk("toggle_cnt", 32'(acc_val.size()), 32'd3);
    if (acc_val.size() == 3) begin
      chk("toggle_r0", 32'(acc_val[0]), 32'd2);
      chk("toggle_r2", 32'(acc_val[2]), 32'd2);
    end

    // Stalled consumer: first result held, second dropped, overrun sticks
    do_reset();
    arm();
    pulse(); gap(4); pulse();
    chk("stall_valid", 32'(bus.period_valid), 32'd1);
    chk("stall_out", 32'(bus.period_out), 32'd4);
    chk("stall_ovr0", 32'(overrun), 32'd0);
    gap(4); pulse();
    chk("stall_ovr1", 32'(overrun), 32'd1);
    chk("stall_hold", 32'(bus.period_out), 32'd4);
    repeat (5) tick();
    en = 1'b0;
    tick(); tick();
    chk("stall_en0_valid", 32'(bus.period_valid), 32'd1);
    chk("stall_en0_out", 32'(bus.period_out), 32'd4);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("stall_drain", 32'(bus.period_valid), 32'd0);
    chk("stall_acc_cnt", 32'(acc_val.size()), 32'd1);
    if (acc_val.size() == 1) chk("stall_acc", 32'(acc_val[0]), 32'd4);
    chk("stall_ovr_sticky", 32'(overrun), 32'd1);

    // Ready pulsed in the capture cycle, edges every 6 -> each 6 delivered once
    do_reset();
    arm();
    pulse(); gap(6); pulse();
    gap(6); pulse_rdy();
    chk("sameclk_valid1", 32'(bus.period_valid), 32'd1);
    gap(6); pulse_rdy();
    chk("sameclk_valid2", 32'(bus.period_valid), 32'd1);
    gap(3);
    ready = 1'b1;
    tick(); tick();
    ready = 1'b0;
    chk("sameclk_cnt", 32'(acc_val.size()), 32'd3);
    foreach (acc_val[i]) chk("sameclk_val", 32'(acc_val[i]), 32'd6);
    chk("sameclk_overrun", 32'(overrun), 32'd0);
    chk("sameclk_empty", 32'(bus.period_valid), 32'd0);

    // Reset with a pending result and mid-measurement; then 5-cycle edges
    do_reset();
    arm();
    pulse(); gap(3); pulse();
    gap(2);
    do_reset();
    chk("midrst_valid", 32'(bus.period_valid), 32'd0);
    chk("midrst_out", 32'(bus.period_out), 32'd0);
    ready = 1'b1;
    arm();
    pulse();
    tick();
    chk("midrst_first_edge", 32'(bus.period_valid), 32'd0);
    gap(4); pulse();
    repeat (3) tick();
    chk("midrst_cnt", 32'(acc_val.size()), 32'd1);
    if (acc_val.size() == 1) chk("midrst_val", 32'(acc_val[0]), 32'd5);

`ifndef PERIOD_METER_TIMEOUT_EN
    // W=4 saturation: 20-cycle period -> 15 with ovf, then 3 without
    do_reset();
    ready = 1'b1;
    arm();
    pulse(); gap(20); pulse();
    chk("sat_valid", 32'(bus4.period_valid), 32'd1);
    chk("sat_out", 32'(bus4.period_out), 32'd15);
    chk("sat_ovf", 32'(bus4.period_ovf), 32'd1);
    chk("sat_wide_out", 32'(bus.period_out), 32'd20);
    gap(3); pulse();
    chk("sat_next_out", 32'(bus4.period_out), 32'd3);
    chk("sat_next_ovf", 32'(bus4.period_ovf), 32'd0);
`else
    // Timeout: one edge then silence -> 50 with tmo; then 8-cycle period
    do_reset();
    ready = 1'b1;
    arm();
    pulse();
    repeat (60) tick();
    chk("tmo_cnt", 32'(acc_val.size()), 32'd1);
    if (acc_val.size() == 1) begin
      chk("tmo_val", 32'(acc_val[0]), 32'd50);
      chk("tmo_flag", 32'(acc_tmo[0]), 32'd1);
    end
    pulse(); gap(8); pulse();
    repeat (3) tick();
    chk("tmo_next_cnt", 32'(acc_val.size()), 32'd2);
    if (acc_val.size() == 2) begin
      chk("tmo_next_val", 32'(acc_val[1]), 32'd8);
      chk("tmo_next_flag", 32'(acc_tmo[1]), 32'd0);
    end
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
